fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_pkg.sv | 22 ++
 rtl/fpu_tag_pipe.sv | 39 +++
 rtl/fpu_issue_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared types for the FPU issue controller: tag entry and id width.
// No logic; types and constants only.
// Not applicable (no handshake).
package fpu_issue_pkg;

    // Widest requester index a tag can carry (up to 16 requesters).
    localparam int FPU_ID_W = 4;

    // One stage of the issue-tag pipe: valid bit plus originating requester.
    typedef struct packed {
        logic                vld;
        logic [FPU_ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{vld: 1'b0, id: '0};

    // Index width actually needed for a given requester count.
    function automatic int fpu_id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// Tag shift register that follows each issued op down the FPU pipeline.
// Latency: LATENCY cycles from tag_in to tag_out.
// No backpressure: advances every cycle; synchronous reset drops all tags.
module fpu_tag_pipe
    import fpu_issue_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [LATENCY];
    tag_t stage_d [LATENCY];

    // Shift every stage one step toward the output.
    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset empties the pipe so stale results are never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= TAG_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Arbitrates NREQ requesters onto a fixed-latency FPU pipe and buffers results in order.
// Latency: accept t -> fpu_start t+1 -> buffer write t+1+LATENCY -> res_valid t+2+LATENCY.
// Backpressure: credit based; a request is accepted only if a result slot is reserved for it.
// Build option FPU_ISSUE_RR_EN: round-robin arbitration (default: fixed priority, lowest index).
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter  int NREQ       = 2,
    parameter  int DATA_W     = 64,
    parameter  int RES_W      = 32,
    parameter  int LATENCY    = 4,
    parameter  int RBUF_DEPTH = 4,
    localparam int ID_W       = fpu_id_w(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   fpu_start,
    output logic [DATA_W-1:0]      fpu_op,
    input  logic [RES_W-1:0]       fpu_res,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [RES_W-1:0]       res_data,
    output logic                   busy
);

    localparam int PTR_W = $clog2(RBUF_DEPTH);
    localparam int CNT_W = $clog2(RBUF_DEPTH + 1);

    // occ_q counts slots claimed (in flight + buffered); credits = RBUF_DEPTH - occ_q.
    logic                init_q, init_d;
    logic                fpu_start_q, fpu_start_d;
    logic [DATA_W-1:0]   fpu_op_q, fpu_op_d;
    logic [ID_W-1:0]     op_id_q, op_id_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0]    infl_q, infl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]     buf_id_q  [RBUF_DEPTH];
    logic [ID_W-1:0]     buf_id_d  [RBUF_DEPTH];
    logic [RES_W-1:0]    buf_res_q [RBUF_DEPTH];
    logic [RES_W-1:0]    buf_res_d [RBUF_DEPTH];
`ifdef FPU_ISSUE_RR_EN
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    logic                any_vld;
    logic [ID_W-1:0]     win;
    logic                credit_ok;
    logic                accept;
    logic                pop;
    logic                wr;
    tag_t                tag_in;
    tag_t                tag_out;
    logic                unused_tag_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pick the winner: first valid requester scanning upward from the priority base.
    always_comb begin : arb
        int base;
        int idx;
        win     = '0;
        any_vld = 1'b0;
        idx     = 0;
`ifdef FPU_ISSUE_RR_EN
        base    = int'(rr_ptr_q);
`else
        base    = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = base + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                win     = ID_W'(idx);
            end
        end
    end

    // A pop in the same cycle frees a slot immediately, so a full controller can still accept.
    assign res_valid = !rst && (cnt_q != '0);
    assign pop       = res_valid && res_ready;
    assign credit_ok = (occ_q < CNT_W'(RBUF_DEPTH)) || pop;
    assign accept    = any_vld && credit_ok && !rst && !init_q;
    assign wr        = tag_out.vld;

    // Only the winner sees ready, and only when the op is actually taken.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    // Next-state for issue register, counters, pointers and result buffer.
    always_comb begin
        init_d      = 1'b0;
        fpu_start_d = accept;
        fpu_op_d    = fpu_op_q;
        op_id_d     = op_id_q;
        if (accept) begin
            fpu_op_d = req_data[int'(win)*DATA_W +: DATA_W];
            op_id_d  = win;
        end
        occ_d    = occ_q + CNT_W'(accept) - CNT_W'(pop);
        infl_d   = infl_q + CNT_W'(accept) - CNT_W'(wr);
        cnt_d    = cnt_q + CNT_W'(wr) - CNT_W'(pop);
        wr_ptr_d = wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        buf_id_d  = buf_id_q;
        buf_res_d = buf_res_q;
        if (wr) begin
            buf_id_d[wr_ptr_q]  = tag_out.id[ID_W-1:0];
            buf_res_d[wr_ptr_q] = fpu_res;
        end
`ifdef FPU_ISSUE_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(win) == NREQ - 1) ? '0 : win + ID_W'(1);
        end
`endif
    end

    // Control state; reset empties everything and blocks accepts for one more cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q      <= 1'b1;
            fpu_start_q <= 1'b0;
            fpu_op_q    <= '0;
            op_id_q     <= '0;
            occ_q       <= '0;
            infl_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef FPU_ISSUE_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            init_q      <= init_d;
            fpu_start_q <= fpu_start_d;
            fpu_op_q    <= fpu_op_d;
            op_id_q     <= op_id_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef FPU_ISSUE_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Result storage; contents are qualified by cnt_q so it needs no reset.
    always_ff @(posedge clk) begin
        buf_id_q  <= buf_id_d;
        buf_res_q <= buf_res_d;
    end

    // Tag enters alongside fpu_start so it pops out the cycle fpu_res is valid.
    assign tag_in.vld = fpu_start_q;
    assign tag_in.id  = FPU_ID_W'(op_id_q);

    fpu_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Id bits above ID_W are always zero.
    assign unused_tag_id = ^tag_out.id;

    assign fpu_start = fpu_start_q && !rst;
    assign fpu_op    = fpu_op_q;
    assign res_id    = buf_id_q[rd_ptr_q];
    assign res_data  = buf_res_q[rd_ptr_q];
    assign busy      = !rst && ((infl_q != '0) || (cnt_q != '0));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: default instance plus a deeper-buffer instance for throughput.
// The FPU pipe is modelled as a LATENCY-deep delay returning the low 32 bits of the op.
// Expected grant order follows FPU_ISSUE_RR_EN when defined.
module tb_fpu_issue_ctrl;

    localparam int LAT = 4;
`ifdef FPU_ISSUE_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] res;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [127:0] req_data;
    logic         fpu_start;
    logic [63:0]  fpu_op;
    logic [31:0]  fpu_res;
    logic         res_valid, res_ready;
    logic [0:0]   res_id;
    logic [31:0]  res_data;
    logic         busy;

    logic [1:0]   tp_req_valid, tp_req_ready;
    logic [127:0] tp_req_data;
    logic         tp_fpu_start;
    logic [63:0]  tp_fpu_op;
    logic [31:0]  tp_fpu_res;
    logic         tp_res_valid, tp_res_ready;
    logic [0:0]   tp_res_id;
    logic [31:0]  tp_res_data;
    logic         tp_busy;

    logic [31:0]  mp    [LAT];
    logic [31:0]  tp_mp [LAT];

    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_pop = 0;
    int   seq   = 0;
    exp_t exp_q [$];

    fpu_issue_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .fpu_start (fpu_start),
        .fpu_op    (fpu_op),
        .fpu_res   (fpu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    fpu_issue_ctrl #(
        .RBUF_DEPTH (LAT + 2)
    ) u_dut_tp (
        .clk       (clk),
        .rst       (rst),
        .req_valid (tp_req_valid),
        .req_ready (tp_req_ready),
        .req_data  (tp_req_data),
        .fpu_start (tp_fpu_start),
        .fpu_op    (tp_fpu_op),
        .fpu_res   (tp_fpu_res),
        .res_valid (tp_res_valid),
        .res_ready (tp_res_ready),
        .res_id    (tp_res_id),
        .res_data  (tp_res_data),
        .busy      (tp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU pipe models: result valid LATENCY cycles after fpu_start, garbage otherwise.
    always @(posedge clk) begin
        mp[0]    <= fpu_start ? fpu_op[31:0] : 32'hDEAD_BEEF;
        tp_mp[0] <= tp_fpu_start ? tp_fpu_op[31:0] : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) begin
            mp[i]    <= mp[i-1];
            tp_mp[i] <= tp_mp[i-1];
        end
    end
    assign fpu_res    = mp[LAT-1];
    assign tp_fpu_res = tp_mp[LAT-1];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive main-DUT inputs for this cycle; lane i carries low word {seq, i}.
    task automatic drive(input logic [1:0] v, input logic rr);
        req_valid = v;
        res_ready = rr;
        req_data  = {32'h0, 16'(seq), 16'h0001, 32'h0, 16'(seq), 16'h0000};
        seq++;
        #1;
    endtask

    // Record accepts into the scoreboard, check pops against it, then advance one clock.
    task automatic cyc();
        exp_t e;
        if ($countones(req_ready) > 1) begin
            chk("ready_onehot", 64'(req_ready), 64'd0);
        end
        if ((req_valid & req_ready) != 2'b00) begin
            e.id  = req_ready[1];
            e.res = req_ready[1] ? req_data[95:64] : req_data[31:0];
            exp_q.push_back(e);
            n_acc++;
        end
        if (res_valid && res_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_res_id", 64'(res_id), 64'(e.id));
                chk("sb_res_data", 64'(res_data), 64'(e.res));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        logic [1:0]  exp_g;
        logic [0:0]  exp_id;

        rst          = 1'b1;
        req_valid    = '0;
        res_ready    = 1'b0;
        req_data     = '0;
        tp_req_valid = '0;
        tp_res_ready = 1'b0;
        tp_req_data  = '0;

        // Reset: outputs quiet while rst is high, even with requests pending.
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 1'b1);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_start", 64'(fpu_start), 64'd0);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            cyc();
        end
        rst = 1'b0;
        drive(2'b11, 1'b0);
        chk("post_rst_ready", 64'(req_ready), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        cyc();
        drive(2'b00, 1'b1);
        cyc();

        // Single op from requester 0.
        drive(2'b01, 1'b1);
        req_data[63:0] = 64'h0000_0001_3F80_0000;
        #1;
        chk("t1_ready", 64'(req_ready), 64'd1);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        cyc();
        drive(2'b00, 1'b1);
        chk("t1_start", 64'(fpu_start), 64'd1);
        chk("t1_op", fpu_op, 64'h0000_0001_3F80_0000);
        chk("t1_busy", 64'(busy), 64'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b1);
            chk("t1_rv_early", 64'(res_valid), 64'd0);
            if (i == 0) chk("t1_start_once", 64'(fpu_start), 64'd0);
            cyc();
        end
        drive(2'b00, 1'b1);
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_res_id", 64'(res_id), 64'd0);
        chk("t1_res_data", 64'(res_data), 64'h3F80_0000);
        cyc();
        drive(2'b00, 1'b1);
        chk("t1_res_gone", 64'(res_valid), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        cyc();

        // Backpressure: buffer full after exactly four accepts.
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 1'b0);
            if (i >= 4) chk("bp_ready_zero", 64'(req_ready), 64'd0);
            cyc();
        end
        chk("bp_accepts", 64'(n_acc - acc0), 64'd4);
        acc0 = n_acc;
        drive(2'b11, 1'b1);
        chk("bp_head_valid", 64'(res_valid), 64'd1);
        chk("bp_pop_accept", 64'(req_ready != 2'b00), 64'd1);
        cyc();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 1'b0);
            chk("bp_ready_after_pop", 64'(req_ready), 64'd0);
            cyc();
        end
        chk("bp_extra_accepts", 64'(n_acc - acc0), 64'd1);

        // Accept and pop together at zero credits: credits stay zero.
        drive(2'b11, 1'b1);
        chk("full_head_valid", 64'(res_valid), 64'd1);
        chk("full_pop_accept", 64'(req_ready != 2'b00), 64'd1);
        cyc();
        drive(2'b11, 1'b0);
        chk("full_credit_zero", 64'(req_ready), 64'd0);
        cyc();
        for (int i = 0; i < 14; i++) begin
            drive(2'b00, 1'b1);
            cyc();
        end
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_count", 64'(n_pop), 64'(n_acc));
        chk("drain_busy", 64'(busy), 64'd0);

        // Reset with three ops in flight: nothing comes back afterwards.
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b1);
            chk("rif_accept", 64'(req_ready), 64'd1);
            cyc();
        end
        rst = 1'b1;
        drive(2'b00, 1'b1);
        cyc();
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            drive(2'b00, 1'b1);
            chk("rif_res_valid", 64'(res_valid), 64'd0);
            chk("rif_busy", 64'(busy), 64'd0);
            cyc();
        end

        // Grant order with both requesters always valid.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1);
            exp_g = (RR_EN && (k % 2 == 1)) ? 2'b10 : 2'b01;
            chk("grant_order", 64'(req_ready), 64'(exp_g));
            cyc();
        end
        for (int i = 0; i < 14; i++) begin
            drive(2'b00, 1'b1);
            cyc();
        end
        chk("grant_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("grant_busy", 64'(busy), 64'd0);

        // Throughput: 16 back-to-back ops finish in 16+LATENCY+2 cycles.
        tp_res_ready = 1'b1;
        for (int c = 0; c < 16 + LAT + 2; c++) begin
            tp_req_valid = (c < 16) ? 2'b11 : 2'b00;
            tp_req_data  = {32'h0, 16'(c), 16'h0001, 32'h0, 16'(c), 16'h0000};
            #1;
            if (c < 16) chk("tp_accept", 64'(tp_req_ready != 2'b00), 64'd1);
            if (c >= LAT + 2) begin
                exp_id = (RR_EN && ((c - LAT - 2) % 2 == 1)) ? 1'b1 : 1'b0;
                chk("tp_res_valid", 64'(tp_res_valid), 64'd1);
                chk("tp_res_id", 64'(tp_res_id), 64'(exp_id));
                chk("tp_res_data", 64'(tp_res_data), 64'({16'(c - LAT - 2), 15'd0, exp_id}));
            end else begin
                chk("tp_res_idle", 64'(tp_res_valid), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        tp_req_valid = 2'b00;
        #1;
        chk("tp_done_valid", 64'(tp_res_valid), 64'd0);
        chk("tp_done_busy", 64'(tp_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
